serial_mem_bridge: RTL and testbench
====================================

// Module: serial_mem_bridge
// PURPOSE
//  Memory-side partner of the byte-serial CPU bus handler. It consumes the 9-phase frame:
//   - phase 0: sync
//   - phases 1-4: address and write-data bytes, LSB first
//   - phases 5-8: read-data bytes returned to the CPU
//  It reassembles 32-bit address/data and issues one req/ack access per frame to a 32-bit
//  memory. Reads are pipelined: read data returned in frame N is the most recent completed
//  read (one-frame lag).
// PARAMETERS
//  AW       32  mem_addr width; frame address is truncated to AW LSBs
//  RST_DATA 0   reset value of the read buffer
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst          in   1   asynchronous, active-high reset
//  frm_sync     in   1   high for the phase-0 cycle of a frame
//  bus_addr     in   8   address byte, valid phases 1-4
//  bus_wdata    in   8   write-data byte, valid phases 1-4
//  bus_wr       in   1   1 = write frame; sampled in phase 1
//  bus_rdata    out  8   read-data byte, phases 5-8
//  bus_rdata_oe out  1   drive enable for bus_rdata
//  mem_req      out  1   access request, held until mem_ack
//  mem_we       out  1   1 = write access
//  mem_addr     out  AW  access address
//  mem_wdata    out  32  write data
//  mem_ack      in   1   access done; mem_rdata valid this cycle on reads
//  mem_rdata    in   32  read data
//  frame_err    out  1   one-cycle pulse on framing error or overrun
//  err_cnt      out  8   saturating error count
// BEHAVIOUR
//  Reset: ph=0, addr/wdata shift regs=0, rd_buf=tx_q=RST_DATA, all outputs 0.
//  Phase counter ph (0..8):
//   - frm_sync=1 -> ph<=1 next cycle.
//   - ph in 1..7 -> ph+1.
//   - ph=8 -> 0.
//   - ph=0 without frm_sync -> stays 0.
//  Capture:
//   - in cycle with ph=k (k=1..4): addr_q[8(k-1)+:8]<=bus_addr; wd_q[8(k-1)+:8]<=bus_wdata.
//   - ph=1 also captures wr_q<=bus_wr.
//   - Byte slices are disjoint [7:0],[15:8],[23:16],[31:24].
//  Issue, at the end of the ph=4 cycle:
//   - Completed address = {bus_addr, addr_q[23:0]}; completed data likewise.
//   - If mem idle (mem_req=0, or mem_ack=1 this cycle): mem_req<=1, mem_we<=wr_q,
//     mem_addr<=completed addr[AW-1:0], mem_wdata<=completed data.
//   - If mem busy: overrun; frame dropped; frame_err pulse; err_cnt+1.
//  Memory FSM, M_IDLE -> M_BUSY on issue:
//   - In M_BUSY, mem_req/mem_we/mem_addr/mem_wdata are held stable until mem_ack.
//   - On mem_ack: mem_req<=0, M_IDLE; if !mem_we, rd_buf<=mem_rdata.
//   - mem_ack while idle is ignored.
//  Response:
//   - On the ph=4->5 edge: tx_q<=rd_buf, or mem_rdata if a read ack lands that same cycle.
//   - While ph in 5..8: bus_rdata=tx_q[8(ph-5)+:8] (combinational mux), bus_rdata_oe=!wr_q.
//   - At all other ph: bus_rdata=0, bus_rdata_oe=0.
//  Framing error:
//   - frm_sync while ph in 1..8 -> frame_err pulse, err_cnt+1, ph<=1 (new frame starts).
//   - If ph was 1..4, the partial frame is discarded and no request is made.
//   - An already-issued request still completes normally.
//  err_cnt saturates at 255. Simultaneous overrun and sync error in one cycle count once.
//  Async reset mid-access drops mem_req immediately; memory must tolerate an abandoned request.
// STRUCTURE
//  Shared package (bus_pkg): FRAME_PHASES=9, ADDR_PH_FIRST=1, ADDR_PH_LAST=4,
//  RESP_PH_FIRST=5, RESP_PH_LAST=8, typedef mem_state_t {M_IDLE, M_BUSY}.
//  One sub-module, frame_deser: ph counter plus the two byte shift/capture registers.
//  The memory FSM, response mux and error logic stay in the top.
// TESTING
//  - Write frame: addr 0x12345678, data 0xCAFEBABE, wr=1
//    -> mem_req@ph5 with addr 0x12345678, wdata 0xCAFEBABE, we=1; bus_rdata_oe=0 phases 5-8.
//  - Read 0x10, mem returns 0xDEADBEEF with ack after 2 cycles; next read frame
//    -> bus_rdata 0xEF,0xBE,0xAD,0xDE on phases 5-8; oe=1.
//  - Hold mem_ack low across two full frames -> second frame dropped, frame_err pulse,
//    err_cnt=1, mem_addr unchanged.
//  - frm_sync asserted at ph=3 -> frame_err, ph restarts at 1, no mem_req from the partial frame.
//  - Assert rst at ph=6 with mem_req=1 -> all outputs 0 immediately; ph=0; first post-reset
//    read frame returns RST_DATA bytes.
//  - 300 consecutive sync errors -> err_cnt saturates at 0xFF.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared frame layout constants and memory-side state type for the
// byte-serial CPU bus bridge.
package bus_pkg;

   localparam int FRAME_PHASES = 9;
   localparam int PH_W         = $clog2(FRAME_PHASES);

   typedef logic [PH_W-1:0] ph_t;

   localparam ph_t ADDR_PH_FIRST = ph_t'(1);
   localparam ph_t ADDR_PH_LAST  = ph_t'(4);
   localparam ph_t RESP_PH_FIRST = ph_t'(5);
   localparam ph_t RESP_PH_LAST  = ph_t'(8);

   // The final address/data byte is consumed straight off the bus at issue,
   // so only the lower bytes need holding registers.
   localparam int LO_BYTES = int'(ADDR_PH_LAST) - int'(ADDR_PH_FIRST);
   localparam int LO_W     = 8 * LO_BYTES;

   typedef enum logic {M_IDLE, M_BUSY} mem_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/frame_deser.sv
// Frame phase counter and little-endian byte capture of the address and
// write-data words carried in phases 1-3 (phase 4 is taken live by the top).
module frame_deser
   import bus_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            frm_sync,
   input  logic [7:0]      bus_addr,
   input  logic [7:0]      bus_wdata,
   input  logic            bus_wr,
   output ph_t             ph,
   output logic [LO_W-1:0] addr_lo,
   output logic [LO_W-1:0] wdata_lo,
   output logic            wr_q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph       <= '0;
         addr_lo  <= '0;
         wdata_lo <= '0;
         wr_q     <= 1'b0;
      end else begin
         // A sync always (re)starts a frame, even in the middle of one.
         if (frm_sync)
            ph <= ADDR_PH_FIRST;
         else if (ph == RESP_PH_LAST)
            ph <= '0;
         else if (ph != '0)
            ph <= ph + ph_t'(1);

         if (ph == ADDR_PH_FIRST)
            wr_q <= bus_wr;

         for (int i = 0; i < LO_BYTES; i++) begin
            if (ph == ADDR_PH_FIRST + ph_t'(i)) begin
               addr_lo[8*i +: 8]  <= bus_addr;
               wdata_lo[8*i +: 8] <= bus_wdata;
            end
         end
      end
   end

endmodule

// File: rtl/serial_mem_bridge.sv
// Memory-side bridge for the 9-phase byte-serial CPU bus: one req/ack access
// per frame, read data returned with a one-frame lag.
module serial_mem_bridge
   import bus_pkg::*;
#(
   parameter int          AW       = 32,
   parameter logic [31:0] RST_DATA = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          frm_sync,
   input  logic [7:0]    bus_addr,
   input  logic [7:0]    bus_wdata,
   input  logic          bus_wr,
   output logic [7:0]    bus_rdata,
   output logic          bus_rdata_oe,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic          mem_ack,
   input  logic [31:0]   mem_rdata,
   output logic          frame_err,
   output logic [7:0]    err_cnt
);

   ph_t             ph;
   logic [LO_W-1:0] addr_lo;
   logic [LO_W-1:0] wdata_lo;
   logic            wr_q;

   frame_deser u_deser (
      .clk       (clk),
      .rst       (rst),
      .frm_sync  (frm_sync),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_wr    (bus_wr),
      .ph        (ph),
      .addr_lo   (addr_lo),
      .wdata_lo  (wdata_lo),
      .wr_q      (wr_q)
   );

   mem_state_t    state_reg, state_next;
   logic          mem_we_reg, mem_we_next;
   logic [AW-1:0] mem_addr_reg, mem_addr_next;
   logic [31:0]   mem_wdata_reg, mem_wdata_next;
   logic [31:0]   rd_buf_reg;
   logic [31:0]   tx_q_reg;
   logic [7:0]    err_cnt_reg;
   logic          frame_err_reg;

   logic [31:0] comp_addr;
   logic [31:0] comp_data;
   logic        issue;
   logic        sync_err;
   logic        overrun;
   logic        ack_read;

   assign comp_addr = {bus_addr, addr_lo};
   assign comp_data = {bus_wdata, wdata_lo};
   // A sync landing on the last address phase aborts the frame before issue.
   assign issue     = (ph == ADDR_PH_LAST) && !frm_sync;
   assign sync_err  = frm_sync && (ph != '0);
   assign ack_read  = (state_reg == M_BUSY) && mem_ack && !mem_we_reg;

   always_comb begin
      state_next     = state_reg;
      mem_we_next    = mem_we_reg;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;
      overrun        = 1'b0;
      case (state_reg)
         M_IDLE: begin
            if (issue) begin
               state_next     = M_BUSY;
               mem_we_next    = wr_q;
               mem_addr_next  = comp_addr[AW-1:0];
               mem_wdata_next = comp_data;
            end
         end
         M_BUSY: begin
            if (mem_ack)
               state_next = M_IDLE;
            // An ack in the issue cycle frees the port for a back-to-back access.
            if (issue) begin
               if (mem_ack) begin
                  state_next     = M_BUSY;
                  mem_we_next    = wr_q;
                  mem_addr_next  = comp_addr[AW-1:0];
                  mem_wdata_next = comp_data;
               end else begin
                  overrun = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= M_IDLE;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         rd_buf_reg    <= RST_DATA;
         tx_q_reg      <= RST_DATA;
         err_cnt_reg   <= '0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
         if (ack_read)
            rd_buf_reg <= mem_rdata;
         if (issue)
            tx_q_reg <= ack_read ? mem_rdata : rd_buf_reg;
         frame_err_reg <= sync_err || overrun;
         if (sync_err || overrun)
            err_cnt_reg <= sat_inc8(err_cnt_reg);
      end
   end

   logic [7:0] resp_bytes [4];

   for (genvar gi = 0; gi < 4; gi++) begin : g_resp
      assign resp_bytes[gi] = tx_q_reg[8*gi +: 8];
   end

   always_comb begin
      bus_rdata    = '0;
      bus_rdata_oe = 1'b0;
      if (ph >= RESP_PH_FIRST && ph <= RESP_PH_LAST)
         bus_rdata_oe = !wr_q;
      for (int i = 0; i < 4; i++) begin
         if (ph == RESP_PH_FIRST + ph_t'(i))
            bus_rdata = resp_bytes[i];
      end
   end

   assign mem_req   = (state_reg == M_BUSY);
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign frame_err = frame_err_reg;
   assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_serial_mem_bridge.sv
// Directed bench for serial_mem_bridge: table of whole frames plus hand-built
// sequences for framing errors, mid-access reset and error-count saturation.
module tb_serial_mem_bridge;

   localparam logic [31:0] RST_D = 32'hA5A5_5A5A;
   localparam logic [31:0] JUNK  = 32'hBAD0_BAD0;

   logic        clk;
   logic        rst;
   logic        frm_sync;
   logic [7:0]  bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_wr;
   logic [7:0]  bus_rdata;
   logic        bus_rdata_oe;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        frame_err;
   logic [7:0]  err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   serial_mem_bridge #(.AW(32), .RST_DATA(RST_D)) dut (
      .clk          (clk),
      .rst          (rst),
      .frm_sync     (frm_sync),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_wr       (bus_wr),
      .bus_rdata    (bus_rdata),
      .bus_rdata_oe (bus_rdata_oe),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .frame_err    (frame_err),
      .err_cnt      (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        wr;
      int          ack1_step;
      logic [31:0] ack1_data;
      int          ack2_step;
      logic [31:0] ack2_data;
      logic        exp_we;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
      logic        exp_oe;
      logic        exp_req_end;
      int          exp_errs;
      logic [7:0]  exp_cnt;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock cycle with the given bus/memory inputs; returns #1 after the edge.
   task automatic drive_cycle(input logic sync, input logic [7:0] a, input logic [7:0] d,
                              input logic wr, input logic ack, input logic [31:0] rdata);
      frm_sync  = sync;
      bus_addr  = a;
      bus_wdata = d;
      bus_wr    = wr;
      mem_ack   = ack;
      mem_rdata = rdata;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      logic [31:0] rd, a5, w5;
      logic        req5, we5, ack;
      logic [31:0] ad;
      logic [7:0]  ab, db;
      int          oe_cnt, errs, idle_bad;
      rd = '0; a5 = '0; w5 = '0; req5 = 1'b0; we5 = 1'b0;
      oe_cnt = 0; errs = 0; idle_bad = 0;
      for (int s = 0; s < 9; s++) begin
         if (s == 5) begin
            req5 = mem_req; we5 = mem_we; a5 = mem_addr; w5 = mem_wdata;
         end
         if (s >= 5) begin
            rd[8*(s-5) +: 8] = bus_rdata;
            if (bus_rdata_oe) oe_cnt++;
         end else if (bus_rdata_oe || bus_rdata != 8'h00) begin
            idle_bad++;
         end
         if (frame_err) errs++;
         ab = 8'h00; db = 8'h00;
         if (s >= 1 && s <= 4) begin
            ab = v.addr[8*(s-1) +: 8];
            db = v.data[8*(s-1) +: 8];
         end
         ack = 1'b0; ad = JUNK;
         if (v.ack1_step != 0 && s == v.ack1_step) begin ack = 1'b1; ad = v.ack1_data; end
         if (v.ack2_step != 0 && s == v.ack2_step) begin ack = 1'b1; ad = v.ack2_data; end
         drive_cycle(s == 0, ab, db, (s == 1) ? v.wr : 1'b0, ack, ad);
      end
      chk($sformatf("v%0d mem_req@ph5", idx), req5, 1'b1);
      chk($sformatf("v%0d mem_we", idx), we5, v.exp_we);
      chk($sformatf("v%0d mem_addr", idx), a5, v.exp_addr);
      chk($sformatf("v%0d mem_wdata", idx), w5, v.exp_wdata);
      chk($sformatf("v%0d bus_rdata", idx), rd, v.exp_rdata);
      chk($sformatf("v%0d oe_cycles", idx), oe_cnt, v.exp_oe ? 32'd4 : 32'd0);
      chk($sformatf("v%0d idle_bus", idx), idle_bad, 0);
      chk($sformatf("v%0d frame_err_pulses", idx), errs, v.exp_errs);
      chk($sformatf("v%0d mem_req_end", idx), mem_req, v.exp_req_end);
      chk($sformatf("v%0d err_cnt", idx), err_cnt, v.exp_cnt);
      $display("txn %0d: addr=%h wdata=%h wr=%b -> req_addr=%h rdata=%h oe_cycles=%0d err_cnt=%0d",
               idx, v.addr, v.data, v.wr, a5, rd, oe_cnt, err_cnt);
   endtask

   initial begin
      vec_t rv;

      //           addr          data          wr    a1  a1_data       a2  a2_data       we    exp_addr      exp_wdata     exp_rdata     oe    req_end errs cnt
      vecs[0] = '{32'h12345678, 32'hCAFEBABE, 1'b1, 6, 32'h00000000, 2, 32'h77777777, 1'b1, 32'h12345678, 32'hCAFEBABE, RST_D,        1'b0, 1'b0,   0,   8'd0};
      vecs[1] = '{32'h00000010, 32'hAAAA0001, 1'b0, 6, 32'hDEADBEEF, 0, 32'h0,        1'b0, 32'h00000010, 32'hAAAA0001, RST_D,        1'b1, 1'b0,   0,   8'd0};
      vecs[2] = '{32'h00000020, 32'h00000000, 1'b0, 7, 32'h01020304, 0, 32'h0,        1'b0, 32'h00000020, 32'h00000000, 32'hDEADBEEF, 1'b1, 1'b0,   0,   8'd0};
      vecs[3] = '{32'h00000030, 32'h00000000, 1'b0, 0, 32'h0,        0, 32'h0,        1'b0, 32'h00000030, 32'h00000000, 32'h01020304, 1'b1, 1'b1,   0,   8'd0};
      vecs[4] = '{32'h00000040, 32'h00000000, 1'b0, 2, 32'h55667788, 0, 32'h0,        1'b0, 32'h00000040, 32'h00000000, 32'h55667788, 1'b1, 1'b1,   0,   8'd0};
      vecs[5] = '{32'h00000050, 32'h00000000, 1'b0, 4, 32'h99AABBCC, 0, 32'h0,        1'b0, 32'h00000050, 32'h00000000, 32'h99AABBCC, 1'b1, 1'b1,   0,   8'd0};
      vecs[6] = '{32'h00000060, 32'h11112222, 1'b1, 0, 32'h0,        0, 32'h0,        1'b0, 32'h00000050, 32'h00000000, 32'h99AABBCC, 1'b0, 1'b1,   1,   8'd1};
      vecs[7] = '{32'h00000070, 32'h00000000, 1'b0, 1, 32'h0BADF00D, 7, 32'h13579BDF, 1'b0, 32'h00000070, 32'h00000000, 32'h0BADF00D, 1'b1, 1'b0,   0,   8'd1};
      vecs[8] = '{32'h00000080, 32'hFEEDFACE, 1'b1, 8, 32'h00000000, 0, 32'h0,        1'b1, 32'h00000080, 32'hFEEDFACE, 32'h13579BDF, 1'b0, 1'b0,   0,   8'd1};

      rst = 1'b1; frm_sync = 1'b0; bus_addr = '0; bus_wdata = '0; bus_wr = 1'b0;
      mem_ack = 1'b0; mem_rdata = JUNK;
      repeat (2) @(posedge clk);
      #1;
      chk("rst mem_req", mem_req, 1'b0);
      chk("rst oe", bus_rdata_oe, 1'b0);
      chk("rst bus_rdata", bus_rdata, 8'h00);
      chk("rst err_cnt", err_cnt, 8'h00);
      chk("rst frame_err", frame_err, 1'b0);
      chk("rst mem_addr", mem_addr, 32'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 9; i++) apply_vec(vecs[i], i);

      // Sync at phase 3: partial frame dropped, new frame counts from phase 1.
      drive_cycle(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, JUNK);
      drive_cycle(1'b0, 8'hAA, 8'h11, 1'b1, 1'b0, JUNK);
      drive_cycle(1'b0, 8'hBB, 8'h22, 1'b0, 1'b0, JUNK);
      drive_cycle(1'b1, 8'hCC, 8'h33, 1'b0, 1'b0, JUNK);
      chk("syncerr frame_err", frame_err, 1'b1);
      chk("syncerr err_cnt", err_cnt, 8'd2);
      chk("syncerr no mem_req", mem_req, 1'b0);
      drive_cycle(1'b0, 8'hCD, 8'h00, 1'b0, 1'b0, JUNK);
      chk("syncerr pulse width", frame_err, 1'b0);
      drive_cycle(1'b0, 8'hAB, 8'h00, 1'b0, 1'b0, JUNK);
      drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, JUNK);
      chk("syncerr no early req", mem_req, 1'b0);
      drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, JUNK);
      chk("restart mem_req", mem_req, 1'b1);
      chk("restart mem_addr", mem_addr, 32'h0000ABCD);
      chk("restart rdata ph5", bus_rdata, 8'hDF);
      chk("restart oe ph5", bus_rdata_oe, 1'b1);
      drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 32'h2468ACE0);
      repeat (3) drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, JUNK);
      chk("restart req done", mem_req, 1'b0);
      $display("txn syncerr: restart frame addr=%h err_cnt=%0d", mem_addr, err_cnt);

      // Reset at phase 6 with a request outstanding.
      drive_cycle(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, JUNK);
      drive_cycle(1'b0, 8'h44, 8'h00, 1'b0, 1'b0, JUNK);
      repeat (3) drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, JUNK);
      chk("prerst mem_req", mem_req, 1'b1);
      chk("prerst rdata ph5", bus_rdata, 8'hE0);
      drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, JUNK);
      chk("prerst rdata ph6", bus_rdata, 8'hAC);
      rst = 1'b1;
      #1;
      chk("midrst mem_req", mem_req, 1'b0);
      chk("midrst mem_addr", mem_addr, 32'h0);
      chk("midrst oe", bus_rdata_oe, 1'b0);
      chk("midrst bus_rdata", bus_rdata, 8'h00);
      chk("midrst err_cnt", err_cnt, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      $display("txn reset: mem_req=%b err_cnt=%0d", mem_req, err_cnt);
      rv = '{32'h00000048, 32'h00000000, 1'b0, 6, 32'h31415926, 0, 32'h0,
             1'b0, 32'h00000048, 32'h00000000, RST_D, 1'b1, 1'b0, 0, 8'd0};
      apply_vec(rv, 9);

      // Back-to-back sync errors saturate the counter.
      drive_cycle(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, JUNK);
      for (int i = 1; i <= 300; i++) begin
         drive_cycle(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, JUNK);
         if (i == 254) chk("sat err_cnt@254", err_cnt, 8'd254);
         if (i == 255) chk("sat err_cnt@255", err_cnt, 8'd255);
      end
      chk("sat err_cnt@300", err_cnt, 8'hFF);
      chk("sat frame_err", frame_err, 1'b1);
      chk("sat no mem_req", mem_req, 1'b0);
      repeat (9) drive_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, JUNK);
      chk("sat hold err_cnt", err_cnt, 8'hFF);
      chk("sat quiet frame_err", frame_err, 1'b0);
      chk("sat ph back to idle", bus_rdata_oe, 1'b0);
      $display("txn saturate: err_cnt=%0d", err_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
